// File: rtl/booth32_div_seq.sv
// rtl/booth32_div_seq.sv - sequential 32/32 restoring divider, signed/unsigned, fixed latency
// One quotient bit per clock; sign correction and divide-by-zero handling in a final FIX cycle.
module booth32_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             alu_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             div_by_zero,
  output logic             overflow
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_signed;
  logic [WIDTH-1:0]   r_raw_a;
  logic [WIDTH-1:0]   r_raw_b;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_rem;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;
  logic               w_last;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;
  logic               w_ovf;

  assign w_a_neg = alu_signed & A[WIDTH-1];
  assign w_b_neg = alu_signed & B[WIDTH-1];
  // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
  assign w_a_mag = w_a_neg ? -A : A;
  assign w_b_mag = w_b_neg ? -B : B;

  assign w_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_trial[WIDTH];
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

  assign w_q_fix = (r_sign_a ^ r_sign_b) ? -r_dvd : r_dvd;
  assign w_r_fix = r_sign_a ? -r_rem : r_rem;
  assign w_ovf   = r_signed && (r_raw_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_raw_b == {WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_signed    <= 1'b0;
      r_raw_a     <= '0;
      r_raw_b     <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      QUOTIENT    <= '0;
      REMAINDER   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign_a <= w_a_neg;
            r_sign_b <= w_b_neg;
            r_signed <= alu_signed;
            r_raw_a  <= A;
            r_raw_b  <= B;
            r_dvd    <= w_a_mag;
            r_dvs    <= w_b_mag;
            r_rem    <= '0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          // Quotient bits shift into the vacated dividend LSBs.
          r_rem <= w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_dvs == '0) begin
            QUOTIENT    <= {WIDTH{1'b1}};
            REMAINDER   <= r_raw_a;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            QUOTIENT    <= w_q_fix;
            REMAINDER   <= w_r_fix;
            div_by_zero <= 1'b0;
            overflow    <= w_ovf;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
